// File: rtl/crc_frame_gen_if.sv
// Valid/ready/last stream bundle shared by the framer's input and output sides.
// The master drives data/valid/last; the slave drives ready.
interface crc_frame_gen_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/crc_frame_gen.sv
// Stream framer: passes payload words through and appends a CRC-8 checksum word per frame.
// Optional build macro CRC_FRAME_STATS_EN adds a saturating truncation counter on err_count.
module crc_frame_gen #(
  parameter int unsigned          DATA_WIDTH = 16,
  parameter int unsigned          POLY_WIDTH = 8,
  parameter logic [POLY_WIDTH-1:0] POLY      = 'hAF,
  parameter logic [POLY_WIDTH-1:0] INIT      = 'h00,
  parameter logic [POLY_WIDTH-1:0] XOR_OUT   = 'h00,
  parameter int unsigned          MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  crc_frame_gen_if.slave        s,
  crc_frame_gen_if.master       m,
  output logic [POLY_WIDTH-1:0] crc_o,
  output logic                  crc_valid,
  output logic                  err_oversize,
  output logic [15:0]           err_count
);

  localparam int unsigned CntW = $clog2(MAX_WORDS + 1);
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t MaxCnt = cnt_t'(MAX_WORDS);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StPass   = 2'd1;
  localparam logic [1:0] StAppend = 2'd2;

  logic [1:0]            state_q, state_d;
  cnt_t                  cnt_q, cnt_d;
  logic [POLY_WIDTH-1:0] crc_q, crc_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic [POLY_WIDTH-1:0] crc_o_q, crc_o_d;
  logic                  crc_valid_q, crc_valid_d;
  logic                  err_q, err_d;

  logic                  out_free;
  logic                  s_ready;
  logic                  xfer;
  logic [POLY_WIDTH-1:0] crc_word;
  cnt_t                  cnt_inc;

  // Bit-serial LFSR unrolled across one word, MSB first.
  function automatic logic [POLY_WIDTH-1:0] crc_step(input logic [POLY_WIDTH-1:0] c_in,
                                                     input logic [DATA_WIDTH-1:0] d);
    logic [POLY_WIDTH-1:0] c;
    logic                  fb;
    c = c_in;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      fb = c[POLY_WIDTH-1] ^ d[i];
      c  = {c[POLY_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  assign out_free = !m_valid_q || m.ready;
  assign s_ready  = !rst && out_free && (state_q != StAppend);
  assign xfer     = s.valid && s_ready;
  assign crc_word = crc_q ^ XOR_OUT;
  assign cnt_inc  = cnt_q + cnt_t'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q && !m.ready;
    m_last_d    = m_last_q;
    crc_o_d     = crc_o_q;
    crc_valid_d = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          m_data_d  = s.data;
          m_valid_d = 1'b1;
          m_last_d  = 1'b0;
          crc_d     = crc_step(crc_q, s.data);
          cnt_d     = cnt_t'(1);
          state_d   = s.last ? StAppend : StPass;
        end
      end
      StPass: begin
        if (xfer) begin
          m_data_d  = s.data;
          m_valid_d = 1'b1;
          m_last_d  = 1'b0;
          crc_d     = crc_step(crc_q, s.data);
          cnt_d     = cnt_inc;
          if (s.last || (cnt_inc == MaxCnt)) begin
            state_d = StAppend;
          end
          // A word hitting the limit without s_last closes the frame early.
          err_d = !s.last && (cnt_inc == MaxCnt);
        end
      end
      StAppend: begin
        if (out_free) begin
          m_data_d    = DATA_WIDTH'(crc_word);
          m_valid_d   = 1'b1;
          m_last_d    = 1'b1;
          crc_o_d     = crc_word;
          crc_valid_d = 1'b1;
          crc_d       = INIT;
          cnt_d       = '0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      crc_q       <= INIT;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      crc_o_q     <= '0;
      crc_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      crc_o_q     <= crc_o_d;
      crc_valid_q <= crc_valid_d;
      err_q       <= err_d;
    end
  end

`ifdef CRC_FRAME_STATS_EN
  logic [15:0] err_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= '0;
    end else if (err_q && (err_count_q != 16'hFFFF)) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = 16'h0000;
`endif

  assign s.ready      = s_ready;
  assign m.data       = m_data_q;
  assign m.valid      = m_valid_q;
  assign m.last       = m_last_q;
  assign crc_o        = crc_o_q;
  assign crc_valid    = crc_valid_q;
  assign err_oversize = err_q;

endmodule

// File: tb/tb_crc_frame_gen.sv
// Scoreboard bench for crc_frame_gen: stimulus pushes expected words/CRCs, a monitor pops and checks.
// Uses MAX_WORDS=4 so the truncation path is reachable with short frames.
module tb_crc_frame_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  crc_o;
  logic        crc_valid;
  logic        err_oversize;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;
  int err_seen = 0;
  int last_seen = 0;
  int frames_pushed = 0;

  logic [16:0] exp_q[$];
  logic [7:0]  crc_q[$];

  crc_frame_gen_if #(.DATA_WIDTH(16)) s_bus ();
  crc_frame_gen_if #(.DATA_WIDTH(16)) m_bus ();

  crc_frame_gen #(
    .DATA_WIDTH(16),
    .POLY_WIDTH(8),
    .POLY      (8'hAF),
    .INIT      (8'h00),
    .XOR_OUT   (8'h00),
    .MAX_WORDS (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s           (s_bus),
    .m           (m_bus),
    .crc_o       (crc_o),
    .crc_valid   (crc_valid),
    .err_oversize(err_oversize),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready: always high, or toggling every cycle.
  initial begin
    m_bus.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) m_bus.ready = ~m_bus.ready;
      else m_bus.ready = 1'b1;
    end
  end

  // Monitor: pops expectations on every output transfer and CRC pulse.
  initial begin
    logic        prev_stall;
    logic [16:0] prev_word;
    logic [16:0] exp_w;
    logic [7:0]  exp_c;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_hold", {15'd0, m_bus.valid, m_bus.last, m_bus.data},
                {15'd0, 1'b1, prev_word});
        end
        if (m_bus.valid && m_bus.ready) begin
          if (m_bus.last) last_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_word", {15'd0, m_bus.last, m_bus.data}, 32'hFFFF_FFFF);
          end else begin
            exp_w = exp_q.pop_front();
            check("out_word", {15'd0, m_bus.last, m_bus.data}, {15'd0, exp_w});
          end
        end
        if (crc_valid) begin
          if (crc_q.size() == 0) begin
            check("unexpected_crc", {24'd0, crc_o}, 32'hFFFF_FFFF);
          end else begin
            exp_c = crc_q.pop_front();
            check("crc_o", {24'd0, crc_o}, {24'd0, exp_c});
          end
        end
        if (err_oversize) err_seen++;
        prev_stall = m_bus.valid && !m_bus.ready;
        prev_word  = {m_bus.last, m_bus.data};
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic l);
    logic rdy;
    logic done;
    exp_q.push_back({1'b0, d});
    s_bus.valid = 1'b1;
    s_bus.data  = d;
    s_bus.last  = l;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      rdy = s_bus.ready;
      @(posedge clk);
      #1;
      if (rdy) done = 1'b1;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic push_cs(input logic [7:0] c);
    exp_q.push_back({1'b1, 8'h00, c});
    crc_q.push_back(c);
    frames_pushed++;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && (exp_q.size() != 0 || crc_q.size() != 0); n++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("drain_words", exp_q.size(), 0);
    check("drain_crcs", crc_q.size(), 0);
  endtask

  task automatic check_reset_vals();
    @(negedge clk);
    check("rst_s_ready", {31'd0, s_bus.ready}, 32'd0);
    check("rst_m_valid", {31'd0, m_bus.valid}, 32'd0);
    check("rst_m_last", {31'd0, m_bus.last}, 32'd0);
    check("rst_m_data", {16'd0, m_bus.data}, 32'd0);
    check("rst_crc_o", {24'd0, crc_o}, 32'd0);
    check("rst_crc_valid", {31'd0, crc_valid}, 32'd0);
    check("rst_err_oversize", {31'd0, err_oversize}, 32'd0);
    check("rst_err_count", {16'd0, err_count}, 32'd0);
  endtask

  task automatic do_reset();
    s_bus.valid = 1'b0;
    s_bus.last  = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    check_reset_vals();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_cnt;
    rst         = 1'b1;
    s_bus.valid = 1'b0;
    s_bus.data  = '0;
    s_bus.last  = 1'b0;
    repeat (2) @(posedge clk);
    check_reset_vals();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single-word frame: 0x0001 -> checksum 0xAF.
    send(16'h0001, 1'b1);
    push_cs(8'hAF);
    s_bus.valid = 1'b0;
    drain();

    // Two-word frame -> checksum 0xF1.
    send(16'h0000, 1'b0);
    send(16'h0002, 1'b1);
    push_cs(8'hF1);
    s_bus.valid = 1'b0;
    drain();

    // Same frame under toggling downstream ready.
    rdy_mode = 1;
    send(16'h0000, 1'b0);
    send(16'h0002, 1'b1);
    push_cs(8'hF1);
    s_bus.valid = 1'b0;
    drain();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Six words, no s_last, MAX_WORDS=4: truncated after word 4.
    send(16'h0000, 1'b0);
    send(16'h0000, 1'b0);
    send(16'h0000, 1'b0);
    send(16'h0001, 1'b0);
    push_cs(8'hAF);
    send(16'h0000, 1'b0);
    send(16'h0002, 1'b0);
    s_bus.valid = 1'b0;
    drain();
    check("err_oversize_pulses", err_seen, 1);
`ifdef CRC_FRAME_STATS_EN
    exp_cnt = 16'd1;
`else
    exp_cnt = 16'd0;
`endif
    check("err_count", {16'd0, err_count}, {16'd0, exp_cnt});
    check("crc_o_held", {24'd0, crc_o}, 32'h0000_00AF);
    do_reset();

    // Reset after 2 words of a 3-word frame, then a fresh frame.
    send(16'h0001, 1'b0);
    send(16'h0002, 1'b0);
    s_bus.valid = 1'b0;
    drain();
    do_reset();
    send(16'h0001, 1'b1);
    push_cs(8'hAF);
    s_bus.valid = 1'b0;
    drain();

    // Back-to-back frames with s_valid held high.
    send(16'h0001, 1'b1);
    push_cs(8'hAF);
    send(16'h0000, 1'b0);
    send(16'h0002, 1'b1);
    push_cs(8'hF1);
    s_bus.valid = 1'b0;
    drain();
    check("m_last_count", last_seen, frames_pushed);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
